dispatch_ctrl: RTL and testbench
================================

Name: dispatch_ctrl

Overview:
- Sequences decoded instructions from the fetch stage into the three issue queues (ALU, MEM, BR).
- Buffers fetched instructions in a 2-entry FIFO and decodes the FIFO head using the team's decode rules (same opcode/field map as the signal decoder).
- Allocates ROB tags in order and stalls on a full target queue, a full ROB, or a flush.
- Sits between fetch and rename/issue in the out-of-order core.

Parameters:
- ROB_DEPTH, 16, number of ROB entries; tags wrap modulo ROB_DEPTH.
- TAG_W, 4, ROB tag width; must satisfy 2**TAG_W >= ROB_DEPTH.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  FIFO can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  32  instruction PC.
- flush  in  1  pipeline flush (branch mispredict).
- flush_tag  in  TAG_W  next ROB tag to allocate after a flush.
- rob_full  in  1  ROB cannot allocate.
- alu_valid / mem_valid / br_valid  out  1 each  dispatch request to each queue.
- alu_ready / mem_ready / br_ready  in  1 each  queue has space.
- d_rs1, d_rs2, d_rd  out  5 each  decoded registers.
- d_aluop  out  3  decoded ALUOp.
- d_opcode  out  7  instr[6:0].
- d_pc  out  32  PC of the dispatched instruction.
- d_tag  out  TAG_W  allocated ROB tag.
- illegal  out  1  one-cycle pulse when an unknown opcode is dropped.

Behaviour:
- Reset (rst_n=0, async): FIFO empty (count=0, rd/wr pointers 0), tag counter 0, illegal=0. All *_valid outputs are 0 because the FIFO is empty. in_ready = 1 once flush=0.
- in_ready = (count<2) && !flush. It does not depend on same-cycle pop, so there is no push-when-full bypass.
- Push: in_valid && in_ready stores {instr, pc} at wr_ptr. Pointers are 1 bit and wrap.
- Decode is combinational on the FIFO head:
  - 0010011: ALUOp 011, ALU, uses rs1.
  - 0110111: ALUOp 100, ALU, no sources.
  - 0110011: ALUOp 010, ALU, rs1+rs2.
  - 0000011: ALUOp 000, MEM, rs1.
  - 0100011: ALUOp 000, MEM, rs1+rs2, rd=0.
  - 1100011: ALUOp 001, BR, rs1+rs2, rd=0.
  - 1100111: ALUOp 110, ALU, rs1.
  - Other opcodes: illegal.
  - Unused register fields drive 0.
- Routing priority: mem flag → MEM queue, else br flag → BR queue, else ALU queue. Exactly one *_valid can be high.
- Dispatch valid for the target queue = head_valid && legal && !rob_full && !flush.
- Fire = target valid && target ready. Fire pops the head, drives d_tag = tag counter, then the tag counter increments (ROB_DEPTH-1 → 0).
- Latency: an instruction pushed in cycle N is visible on the d_* outputs in cycle N+1 at the earliest.
- Illegal head (not flushed): popped in one cycle regardless of rob_full or queue ready. No tag is consumed. illegal=1 (registered) the following cycle.
- Stall: valid stays asserted and d_* stay stable until the target ready is high. rob_full drops valid but holds the head.
- Flush: in the same cycle, all valids=0 and no push. At the edge, count←0, pointers←0, tag←flush_tag. Flush has priority over push and fire in that cycle.
- Push and pop in the same cycle: count unchanged.
- d_* outputs are don't-care when all valids are 0; drive them from the head regardless.

Optional Feature:
- Macro DISPATCH_STATS_EN.
- When defined, adds three outputs:
  - stat_disp (32 bits): increments on every fire.
  - stat_stall (32 bits): increments when the head is legal and not flushed but no fire occurs.
  - stat_ill (16 bits): increments on every illegal drop.
- All three counters reset to 0 on rst_n, saturate at all-ones, and are not cleared by flush.
- Without the macro, these ports and counters do not exist.

Test Plan:
- Reset, all readies=1, push addi x5,x1,3 (0x00308293) at pc 0x100 → next cycle alu_valid=1, rd=5, rs1=1, rs2=0, aluop=011, d_tag=0; the tag becomes 1 after the fire.
- Push sw x2,4(x3) with mem_ready=0 for 3 cycles, then push 2 more → mem_valid held 3 cycles with fields stable; in_ready=0 once count=2; the sw fires when mem_ready=1.
- Push 17 ALU ops back-to-back, ROB_DEPTH=16 → d_tag sequence 0..15,0 (wrap).
- Push opcode 0x7F followed by add → illegal pulses once, no valids for the bad op, add gets the next sequential tag with no gap.
- FIFO full (2 entries), assert flush with flush_tag=9 while in_valid=1 → next cycle count=0 with no dispatch; the next instruction gets d_tag=9.
- rob_full=1 with a BEQ at head and br_ready=1 → br_valid=0, head held; drop rob_full → br_valid=1 with aluop=001, rd=0.

Source files
------------

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: 2-entry fetch FIFO, head decode, in-order ROB tag allocation, ALU/MEM/BR routing.
// Optional saturating statistics counters are enabled by defining DISPATCH_STATS_EN.
module dispatch_ctrl #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    input  logic [TAG_W-1:0] flush_tag,
    input  logic             rob_full,
    output logic             alu_valid,
    output logic             mem_valid,
    output logic             br_valid,
    input  logic             alu_ready,
    input  logic             mem_ready,
    input  logic             br_ready,
    output logic [4:0]       d_rs1,
    output logic [4:0]       d_rs2,
    output logic [4:0]       d_rd,
    output logic [2:0]       d_aluop,
    output logic [6:0]       d_opcode,
    output logic [31:0]      d_pc,
    output logic [TAG_W-1:0] d_tag,
    output logic             illegal
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]      stat_disp,
    output logic [31:0]      stat_stall,
    output logic [15:0]      stat_ill
`endif
);

    typedef enum logic [1:0] {
        Q_ALU,
        Q_MEM,
        Q_BR
    } queue_e;

    logic [63:0]      fifo_q [2];
    logic [63:0]      fifo_d [2];
    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             illegal_q, illegal_d;

    logic [31:0] head_instr;
    logic        head_valid;
    logic        legal;
    queue_e      target;
    logic [2:0]  aluop;
    logic        use_rs1, use_rs2, use_rd;
    logic        disp_ok, tgt_ready, fire, drop, push;
    logic        unused_fields;

    assign head_instr    = fifo_q[rd_ptr_q][63:32];
    assign head_valid    = (count_q != 2'd0);
    assign unused_fields = ^{head_instr[31:25], head_instr[14:12]};

    always_comb begin
        legal   = 1'b1;
        target  = Q_ALU;
        aluop   = 3'b000;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b1;
        case (head_instr[6:0])
            7'b0010011: begin aluop = 3'b011; use_rs1 = 1'b1; end
            7'b0110111: begin aluop = 3'b100; end
            7'b0110011: begin aluop = 3'b010; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            7'b0000011: begin target = Q_MEM; use_rs1 = 1'b1; end
            7'b0100011: begin target = Q_MEM; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b0; end
            7'b1100011: begin
                target  = Q_BR;
                aluop   = 3'b001;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b0;
            end
            7'b1100111: begin aluop = 3'b110; use_rs1 = 1'b1; end
            default: begin legal = 1'b0; use_rd = 1'b0; end
        endcase
    end

    assign d_rs1    = use_rs1 ? head_instr[19:15] : 5'd0;
    assign d_rs2    = use_rs2 ? head_instr[24:20] : 5'd0;
    assign d_rd     = use_rd  ? head_instr[11:7]  : 5'd0;
    assign d_aluop  = aluop;
    assign d_opcode = head_instr[6:0];
    assign d_pc     = fifo_q[rd_ptr_q][31:0];
    assign d_tag    = tag_q;
    assign illegal  = illegal_q;

    assign in_ready  = (count_q < 2'd2) && !flush;
    assign disp_ok   = head_valid && legal && !rob_full && !flush;
    assign alu_valid = disp_ok && (target == Q_ALU);
    assign mem_valid = disp_ok && (target == Q_MEM);
    assign br_valid  = disp_ok && (target == Q_BR);

    always_comb begin
        case (target)
            Q_MEM:   tgt_ready = mem_ready;
            Q_BR:    tgt_ready = br_ready;
            default: tgt_ready = alu_ready;
        endcase
    end

    assign fire = disp_ok && tgt_ready;
    // Illegal heads drain regardless of rob_full/ready so a bad opcode never blocks the FIFO.
    assign drop = head_valid && !legal && !flush;
    assign push = in_valid && in_ready;

    always_comb begin
        fifo_d    = fifo_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tag_d     = tag_q;
        illegal_d = drop;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            tag_d    = flush_tag;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = {in_instr, in_pc};
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (fire || drop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(push) - 2'(fire || drop);
            if (fire) begin
                tag_d = (tag_q == TAG_W'(ROB_DEPTH - 1)) ? '0 : tag_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            count_q   <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            tag_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            fifo_q    <= fifo_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tag_q     <= tag_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [31:0] stat_disp_q, stat_disp_d;
    logic [31:0] stat_stall_q, stat_stall_d;
    logic [15:0] stat_ill_q, stat_ill_d;
    logic        stall;

    assign stall = head_valid && legal && !flush && !fire;

    always_comb begin
        stat_disp_d  = stat_disp_q;
        stat_stall_d = stat_stall_q;
        stat_ill_d   = stat_ill_q;
        if (fire && (stat_disp_q != '1)) begin
            stat_disp_d = stat_disp_q + 32'd1;
        end
        if (stall && (stat_stall_q != '1)) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
        if (drop && (stat_ill_q != '1)) begin
            stat_ill_d = stat_ill_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_disp_q  <= '0;
            stat_stall_q <= '0;
            stat_ill_q   <= '0;
        end else begin
            stat_disp_q  <= stat_disp_d;
            stat_stall_q <= stat_stall_d;
            stat_ill_q   <= stat_ill_d;
        end
    end

    assign stat_disp  = stat_disp_q;
    assign stat_stall = stat_stall_q;
    assign stat_ill   = stat_ill_q;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Scoreboard bench for dispatch_ctrl: directed instructions push expected dispatches into a queue,
// a negedge monitor pops and compares on every fire and every illegal pulse.
module tb_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_pc;
    logic        flush;
    logic [3:0]  flush_tag;
    logic        rob_full;
    logic        alu_valid, mem_valid, br_valid;
    logic        alu_ready, mem_ready, br_ready;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic [2:0]  d_aluop;
    logic [6:0]  d_opcode;
    logic [31:0] d_pc;
    logic [3:0]  d_tag;
    logic        illegal;

    always #5 clk = ~clk;

    dispatch_ctrl #(.ROB_DEPTH(16), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .flush_tag(flush_tag), .rob_full(rob_full),
        .alu_valid(alu_valid), .mem_valid(mem_valid), .br_valid(br_valid),
        .alu_ready(alu_ready), .mem_ready(mem_ready), .br_ready(br_ready),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_aluop(d_aluop), .d_opcode(d_opcode),
        .d_pc(d_pc), .d_tag(d_tag), .illegal(illegal)
    );

    // kind: 0 ALU, 1 MEM, 2 BR, 3 illegal drop
    typedef struct {
        int          kind;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  aluop;
        logic [31:0] pc;
        logic [3:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   nv;
    int   fkind;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic expect_op(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [2:0] aluop,
                             input logic [31:0] pc, input logic [3:0] tag);
        exp_t x;
        x.kind = kind; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2;
        x.aluop = aluop; x.pc = pc; x.tag = tag;
        exp_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles want 1 (pc %0h)", pc);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        check("drain_pending", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (illegal) begin
                n_cmp++;
                if (exp_q.size() == 0 || exp_q[0].kind != 3) begin
                    n_err++;
                    $display("FAIL illegal_pulse: got illegal=1 want no pulse here");
                end else begin
                    e = exp_q.pop_front();
                end
            end
            nv = int'(alu_valid) + int'(mem_valid) + int'(br_valid);
            if (nv > 1) begin
                n_cmp++;
                n_err++;
                $display("FAIL onehot_valid: got %0d valids want at most 1", nv);
            end
            fkind = -1;
            if (alu_valid && alu_ready) fkind = 0;
            if (mem_valid && mem_ready) fkind = 1;
            if (br_valid && br_ready) fkind = 2;
            if (fkind >= 0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_fire: got kind=%0d pc=%0h want no dispatch", fkind, d_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (fkind != e.kind || d_rd !== e.rd || d_rs1 !== e.rs1 || d_rs2 !== e.rs2 ||
                        d_aluop !== e.aluop || d_pc !== e.pc || d_tag !== e.tag) begin
                        n_err++;
                        $display("FAIL dispatch: got kind=%0d rd=%0d rs1=%0d rs2=%0d op=%0b pc=%0h tag=%0d want kind=%0d rd=%0d rs1=%0d rs2=%0d op=%0b pc=%0h tag=%0d",
                                 fkind, d_rd, d_rs1, d_rs2, d_aluop, d_pc, d_tag,
                                 e.kind, e.rd, e.rs1, e.rs2, e.aluop, e.pc, e.tag);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 time units want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; flush_tag = '0; rob_full = 1'b0;
        alu_ready = 1'b1; mem_ready = 1'b1; br_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_alu_valid", alu_valid, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_br_valid", br_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_illegal", illegal, 0);
        check("rst_tag", d_tag, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // addi x5,x1,3
        expect_op(0, 5, 1, 0, 3'b011, 32'h100, 0);
        send(32'h00308293, 32'h100);
        drain();

        // sw x2,4(x3) held by mem_ready=0
        mem_ready = 1'b0;
        expect_op(1, 0, 3, 2, 3'b000, 32'h104, 1);
        send(32'h0021A223, 32'h104);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sw_mem_valid", mem_valid, 1);
            check("sw_rs1", d_rs1, 3);
            check("sw_rs2", d_rs2, 2);
            check("sw_rd", d_rd, 0);
            check("sw_pc", d_pc, 32'h104);
            check("sw_tag", d_tag, 1);
            tick();
        end
        expect_op(0, 7, 5, 6, 3'b010, 32'h108, 2);
        send(32'h006283B3, 32'h108);
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        tick();
        mem_ready = 1'b1;
        expect_op(0, 9, 0, 0, 3'b100, 32'h10C, 3);
        send(32'h123454B7, 32'h10C);
        expect_op(1, 4, 2, 0, 3'b000, 32'h110, 4);
        send(32'h00812203, 32'h110);
        expect_op(0, 1, 6, 0, 3'b110, 32'h114, 5);
        send(32'h000300E7, 32'h114);
        drain();

        // Async reset mid-run, then 17 back-to-back ALU ops: tags 0..15,0
        rst_n = 1'b0;
        @(negedge clk);
        check("rst2_alu_valid", alu_valid, 0);
        check("rst2_tag", d_tag, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            expect_op(0, 1, 2, 0, 3'b011, 32'h400 + 32'(4 * i), 4'(i % 16));
            send((32'(i) << 20) | (32'd2 << 15) | (32'd1 << 7) | 32'h13, 32'h400 + 32'(4 * i));
        end
        drain();

        // Illegal opcode then add: one pulse, add gets tag 1
        expect_op(3, 0, 0, 0, 3'b000, 32'h200, 0);
        send(32'h0000007F, 32'h200);
        @(negedge clk);
        check("ill_no_valid", {29'd0, alu_valid, mem_valid, br_valid}, 0);
        tick();
        expect_op(0, 7, 5, 6, 3'b010, 32'h204, 1);
        send(32'h006283B3, 32'h204);
        drain();

        // Flush with full FIFO and in_valid high
        alu_ready = 1'b0;
        send(32'h00208093, 32'h500);
        send(32'h00308093, 32'h504);
        @(negedge clk);
        check("pre_flush_in_ready", in_ready, 0);
        check("pre_flush_alu_valid", alu_valid, 1);
        tick();
        in_valid = 1'b1; in_instr = 32'h123454B7; in_pc = 32'h5FC;
        flush = 1'b1; flush_tag = 4'd9;
        @(negedge clk);
        check("flush_alu_valid", alu_valid, 0);
        check("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; alu_ready = 1'b1;
        @(negedge clk);
        check("post_flush_empty", {29'd0, alu_valid, mem_valid, br_valid}, 0);
        check("post_flush_in_ready", in_ready, 1);
        check("post_flush_tag", d_tag, 9);
        tick();
        expect_op(0, 9, 0, 0, 3'b100, 32'h508, 9);
        send(32'h123454B7, 32'h508);
        drain();

        // rob_full holds a BEQ at head
        rob_full = 1'b1;
        send(32'h00208063, 32'h300);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("robfull_br_valid", br_valid, 0);
            check("robfull_head_pc", d_pc, 32'h300);
            tick();
        end
        expect_op(2, 0, 1, 2, 3'b001, 32'h300, 10);
        rob_full = 1'b0;
        drain();

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
